// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, precharge-all address and the
// auto-refresh FSM state enum.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  // A10 high selects all banks on PRECHARGE
  localparam logic [10:0] ADDR_PALL = 11'h400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_RP,
    ST_AREF,
    ST_WAIT_RFC,
    ST_DONE
  } aref_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh credit generator: interval counter, saturating refresh debt and a
// sticky overrun flag for credits that arrive while the debt is full.
module sdram_ref_timer #(
  parameter int REF_INTERVAL = 750,
  parameter int MAX_DEBT     = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            init_done,
  input  logic                            dec,
  output logic [$clog2(MAX_DEBT+1)-1:0]   debt,
  output logic                            urgent,
  output logic                            overrun
);

  localparam int CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int DW = $clog2(MAX_DEBT + 1);
  localparam logic [CW-1:0] CNT_TC   = CW'(REF_INTERVAL - 1);
  localparam logic [DW-1:0] DEBT_SAT = DW'(MAX_DEBT);

  logic [CW-1:0] cnt;
  logic          credit;

  assign credit = init_done && (cnt == CNT_TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (!init_done || credit) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // A simultaneous credit and decrement cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debt <= '0;
    end else if (credit && !dec) begin
      if (debt != DEBT_SAT) debt <= debt + 1'b1;
    end else if (dec && !credit) begin
      if (debt != '0) debt <= debt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overrun <= 1'b0;
    else if (credit && debt == DEBT_SAT) overrun <= 1'b1;
  end

  assign urgent = (debt == DEBT_SAT);

endmodule

// File: rtl/sdram_aref_ctrl.sv
// Auto-refresh engine: on grant issues optional PRECHARGE ALL then a burst of
// AUTO REFRESH commands. Define SDRAM_AREF_PRECHARGE_EN to build the PRE phase.
module sdram_aref_ctrl
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 750,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int MAX_DEBT     = 8,
  parameter int BURST_MAX    = 4,
  parameter int ADDR_W       = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          init_done,
  input  logic                          ref_en,
  output logic                          ref_req,
  output logic                          ref_urgent,
  output logic                          ref_end,
  output logic                          ref_overrun,
  output logic [$clog2(MAX_DEBT+1)-1:0] ref_debt,
  output logic [3:0]                    aref_cmd,
  output logic [ADDR_W-1:0]             aref_addr
);

  localparam int BW   = $clog2(BURST_MAX + 1);
  localparam int WMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
  localparam logic [WW-1:0] RFC_LAST  = WW'(T_RFC - 1);
`ifdef SDRAM_AREF_PRECHARGE_EN
  localparam logic [WW-1:0] RP_LAST   = WW'(T_RP - 1);
`endif

  aref_state_e   state, state_nxt;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic          dec;

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_DEBT     (MAX_DEBT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .dec       (dec),
    .debt      (ref_debt),
    .urgent    (ref_urgent),
    .overrun   (ref_overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ref_en && ref_debt != '0) begin
`ifdef SDRAM_AREF_PRECHARGE_EN
          state_nxt = ST_PRE;
`else
          state_nxt = ST_AREF;
`endif
        end
      end
`ifdef SDRAM_AREF_PRECHARGE_EN
      ST_PRE:     state_nxt = ST_WAIT_RP;
      ST_WAIT_RP: if (wcnt == RP_LAST) state_nxt = ST_AREF;
`endif
      ST_AREF:    state_nxt = ST_WAIT_RFC;
      ST_WAIT_RFC: begin
        // debt already reflects the AREF just issued plus any fresh credit
        if (wcnt == RFC_LAST) begin
          if (ref_debt != '0 && bcnt < BURST_LIM) state_nxt = ST_AREF;
          else                                    state_nxt = ST_DONE;
        end
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        wcnt <= '0;
    else if (state_nxt != state)                       wcnt <= '0;
    else if (state == ST_WAIT_RP || state == ST_WAIT_RFC) wcnt <= wcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bcnt <= '0;
    else if (state == ST_IDLE) bcnt <= '0;
    else if (state == ST_AREF) bcnt <= bcnt + 1'b1;
  end

  always_comb begin
    aref_cmd = CMD_NOP;
    case (state)
      ST_PRE:  aref_cmd = CMD_PRE;
      ST_AREF: aref_cmd = CMD_AREF;
      default: aref_cmd = CMD_NOP;
    endcase
  end

  assign dec       = (state == ST_AREF);
  assign ref_end   = (state == ST_DONE);
  assign ref_req   = (ref_debt != '0) && (state == ST_IDLE);
  assign aref_addr = ADDR_W'(ADDR_PALL);

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Bench for sdram_aref_ctrl: directed refresh scenarios plus randomized traffic
// against a timeline-based reference model.
module tb_sdram_aref_ctrl;

  localparam int REF_INTERVAL = 10;
  localparam int T_RP         = 2;
  localparam int T_RFC        = 3;
  localparam int MAX_DEBT     = 8;
  localparam int BURST_MAX    = 4;
  localparam int ADDR_W       = 12;
  localparam int DW           = $clog2(MAX_DEBT + 1);
`ifdef SDRAM_AREF_PRECHARGE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  // offsets counted from the cycle after the grant edge (that cycle is 1)
  localparam int AREF_OFF = PRE_EN ? 2 + T_RP : 1;
  localparam int END_OFF  = AREF_OFF + T_RFC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  logic ref_en = 1'b0;
  logic ref_req, ref_urgent, ref_end, ref_overrun;
  logic [DW-1:0] ref_debt;
  logic [3:0] aref_cmd;
  logic [ADDR_W-1:0] aref_addr;

  int n_cmp = 0;
  int n_err = 0;

  sdram_aref_ctrl #(
    .REF_INTERVAL (REF_INTERVAL), .T_RP (T_RP), .T_RFC (T_RFC),
    .MAX_DEBT (MAX_DEBT), .BURST_MAX (BURST_MAX), .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .init_done (init_done), .ref_en (ref_en),
    .ref_req (ref_req), .ref_urgent (ref_urgent), .ref_end (ref_end),
    .ref_overrun (ref_overrun), .ref_debt (ref_debt),
    .aref_cmd (aref_cmd), .aref_addr (aref_addr)
  );

  always #5 clk = ~clk;

  // Reference model: credits from elapsed init_done time, sequence as a timeline
  // of offsets from the grant (m_t = 0 is the first busy cycle).
  int m_debt = 0, m_since = 0, m_t = 0, m_next = -1, m_last = -1, m_end = -1, m_issued = 0;
  bit m_ovr = 0, m_busy = 0;

  function automatic logic [3:0] exp_cmd();
    if (!m_busy)                  return NOP;
    if (PRE_EN && m_t == 0)       return PRE;
    if (m_t == m_next)            return AREF;
    return NOP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_debt = 0; m_since = 0; m_ovr = 0; m_busy = 0;
      m_t = 0; m_next = -1; m_last = -1; m_end = -1; m_issued = 0;
    end else begin
      bit credit, dec;
      int d;
      credit = 0;
      if (init_done) begin
        m_since++;
        credit = (m_since % REF_INTERVAL) == 0;
      end else m_since = 0;
      dec = m_busy && (m_t == m_next);
      if (credit && m_debt == MAX_DEBT) m_ovr = 1;
      d = m_debt + int'(credit) - int'(dec);
      if (d > MAX_DEBT) d = MAX_DEBT;
      if (m_busy) begin
        if (dec) begin
          m_issued++; m_last = m_t; m_next = -1;
        end else if (m_last >= 0 && m_t == m_last + T_RFC) begin
          if (m_debt != 0 && m_issued < BURST_MAX) m_next = m_t + 1;
          else                                     m_end  = m_t + 1;
          m_last = -1;
        end
        if (m_t == m_end) m_busy = 0;
        m_t++;
      end else if (ref_en && m_debt != 0) begin
        m_busy = 1; m_t = 0; m_next = PRE_EN ? 1 + T_RP : 0;
        m_last = -1; m_end = -1; m_issued = 0;
      end
      m_debt = d;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; init_done = 1'b0; ref_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b0; ref_en = 1'b0;
    #3;
    n_cmp++; if (aref_cmd !== NOP) begin n_err++; $display("FAIL reset_cmd got=%b exp=%b", aref_cmd, NOP); end
    n_cmp++; if (ref_req !== 1'b0 || ref_end !== 1'b0 || ref_urgent !== 1'b0 || ref_overrun !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got req/end/urg/ovr=%b%b%b%b exp=0000", ref_req, ref_end, ref_urgent, ref_overrun);
    end
    n_cmp++; if (ref_debt !== '0) begin n_err++; $display("FAIL reset_debt got=%0d exp=0", ref_debt); end
    n_cmp++; if (aref_addr !== 12'h400) begin n_err++; $display("FAIL reset_addr got=%h exp=400", aref_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_credit();
    init_done = 1'b1;
    for (int i = 1; i <= REF_INTERVAL; i++) begin
      @(negedge clk);
      if (i < REF_INTERVAL) begin
        n_cmp++; if (ref_debt !== '0 || ref_req !== 1'b0 || aref_cmd !== NOP) begin
          n_err++; $display("FAIL credit_early edge=%0d got debt=%0d req=%b cmd=%b exp 0/0/0111", i, ref_debt, ref_req, aref_cmd);
        end
      end else begin
        n_cmp++; if (ref_debt !== DW'(1) || ref_req !== 1'b1) begin
          n_err++; $display("FAIL credit_first got debt=%0d req=%b exp debt=1 req=1", ref_debt, ref_req);
        end
      end
    end
  endtask

  task automatic test_single_seq();
    logic [3:0] ec;
    ref_en = 1'b1;
    @(negedge clk);
    ref_en = 1'b0;
    for (int off = 1; off <= END_OFF + 1; off++) begin
      ec = (PRE_EN && off == 1) ? PRE : (off == AREF_OFF) ? AREF : NOP;
      n_cmp++; if (aref_cmd !== ec) begin n_err++; $display("FAIL single_cmd off=%0d got=%b exp=%b", off, aref_cmd, ec); end
      n_cmp++; if (ref_end !== (off == END_OFF)) begin n_err++; $display("FAIL single_end off=%0d got=%b exp=%b", off, ref_end, off == END_OFF); end
      if (off == END_OFF + 1) begin
        n_cmp++; if (ref_debt !== '0 || ref_req !== 1'b0) begin
          n_err++; $display("FAIL single_after got debt=%0d req=%b exp 0/0", ref_debt, ref_req);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    init_done = 1'b1;
    repeat (85) @(negedge clk);
    n_cmp++; if (ref_debt !== DW'(MAX_DEBT) || ref_urgent !== 1'b1 || ref_overrun !== 1'b0) begin
      n_err++; $display("FAIL sat_8 got debt=%0d urg=%b ovr=%b exp 8/1/0", ref_debt, ref_urgent, ref_overrun);
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (ref_debt !== DW'(MAX_DEBT) || ref_urgent !== 1'b1 || ref_overrun !== 1'b1) begin
      n_err++; $display("FAIL sat_9 got debt=%0d urg=%b ovr=%b exp 8/1/1", ref_debt, ref_urgent, ref_overrun);
    end
  endtask

  task automatic test_burst();
    int n_pre, n_aref, first_off, prev_off, end_off;
    bit gap_bad;
    n_pre = 0; n_aref = 0; first_off = -1; prev_off = -1; end_off = -1; gap_bad = 0;
    do_reset();
    init_done = 1'b1;
    repeat (60) @(negedge clk);
    init_done = 1'b0;   // freeze credits so the residual debt is exact
    ref_en = 1'b1;
    @(negedge clk);
    ref_en = 1'b0;
    for (int off = 1; off <= 40; off++) begin
      if (aref_cmd === PRE) n_pre++;
      if (aref_cmd === AREF) begin
        if (first_off < 0) first_off = off;
        if (prev_off >= 0 && off - prev_off != T_RFC + 1) gap_bad = 1;
        prev_off = off; n_aref++;
      end
      if (ref_end === 1'b1 && end_off < 0) end_off = off;
      if (end_off >= 0 && off == end_off + 1) begin
        n_cmp++; if (ref_req !== 1'b1 || ref_debt !== DW'(2)) begin
          n_err++; $display("FAIL burst_after got req=%b debt=%0d exp 1/2", ref_req, ref_debt);
        end
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (end_off < 0) begin n_err++; $display("FAIL burst_timeout got no ref_end within 40 cycles exp ref_end"); end
    n_cmp++; if (n_pre != int'(PRE_EN) || n_aref != BURST_MAX) begin
      n_err++; $display("FAIL burst_count got pre=%0d aref=%0d exp pre=%0d aref=%0d", n_pre, n_aref, PRE_EN, BURST_MAX);
    end
    n_cmp++; if (first_off != AREF_OFF || gap_bad) begin
      n_err++; $display("FAIL burst_spacing got first=%0d gap_bad=%b exp first=%0d gap=%0d", first_off, gap_bad, AREF_OFF, T_RFC + 1);
    end
    n_cmp++; if (end_off != prev_off + T_RFC + 1) begin
      n_err++; $display("FAIL burst_end got end=%0d exp=%0d", end_off, prev_off + T_RFC + 1);
    end
  endtask

  task automatic test_credit_on_aref();
    do_reset();
    init_done = 1'b1;
    // AREF must land in cycle 2*REF_INTERVAL, whose closing edge carries a credit
    repeat (2 * REF_INTERVAL - AREF_OFF - 1) @(negedge clk);
    ref_en = 1'b1;
    @(negedge clk);
    ref_en = 1'b0;
    repeat (AREF_OFF - 1) @(negedge clk);
    n_cmp++; if (aref_cmd !== AREF || ref_debt !== DW'(1)) begin
      n_err++; $display("FAIL coa_setup got cmd=%b debt=%0d exp cmd=0001 debt=1", aref_cmd, ref_debt);
    end
    @(negedge clk);
    n_cmp++; if (ref_debt !== DW'(1)) begin n_err++; $display("FAIL coa_debt got=%0d exp=1", ref_debt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    init_done = 1'b1;
    repeat (REF_INTERVAL) @(negedge clk);
    ref_en = 1'b1;
    @(negedge clk);
    ref_en = 1'b0;
    repeat (AREF_OFF) @(negedge clk);   // first WAIT_RFC cycle
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (aref_cmd !== NOP || ref_debt !== '0 || ref_req !== 1'b0 || ref_end !== 1'b0 ||
                 ref_urgent !== 1'b0 || ref_overrun !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got cmd=%b debt=%0d req=%b end=%b urg=%b ovr=%b exp reset values",
                        aref_cmd, ref_debt, ref_req, ref_end, ref_urgent, ref_overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int gp;
    do_reset();
    init_done = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      gp = (blk % 3 == 0) ? 0 : (blk % 3 == 1) ? 4 : 20;
      for (int i = 0; i < 250; i++) begin
        @(negedge clk);
        n_cmp++; if (aref_cmd !== exp_cmd()) begin n_err++; $display("FAIL rnd_cmd blk=%0d i=%0d got=%b exp=%b", blk, i, aref_cmd, exp_cmd()); end
        n_cmp++; if (ref_debt !== DW'(m_debt)) begin n_err++; $display("FAIL rnd_debt blk=%0d i=%0d got=%0d exp=%0d", blk, i, ref_debt, m_debt); end
        n_cmp++; if (ref_req !== (!m_busy && m_debt != 0)) begin n_err++; $display("FAIL rnd_req blk=%0d i=%0d got=%b exp=%b", blk, i, ref_req, !m_busy && m_debt != 0); end
        n_cmp++; if (ref_end !== (m_busy && m_t == m_end)) begin n_err++; $display("FAIL rnd_end blk=%0d i=%0d got=%b exp=%b", blk, i, ref_end, m_busy && m_t == m_end); end
        n_cmp++; if (ref_urgent !== (m_debt == MAX_DEBT)) begin n_err++; $display("FAIL rnd_urg blk=%0d i=%0d got=%b exp=%b", blk, i, ref_urgent, m_debt == MAX_DEBT); end
        n_cmp++; if (ref_overrun !== m_ovr) begin n_err++; $display("FAIL rnd_ovr blk=%0d i=%0d got=%b exp=%b", blk, i, ref_overrun, m_ovr); end
        if ($urandom_range(0, 149) == 0) init_done = ~init_done;
        ref_en = (gp != 0) && ($urandom_range(0, gp - 1) == 0);
      end
    end
    ref_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_credit();
    test_single_seq();
    test_saturation();
    test_burst();
    test_credit_on_aref();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
